pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered, parametrised program-counter sequencer for the processor fetch stage.
//  Computes and holds the PC each cycle from a 3-bit PC opcode: increment, jumps, branches, register jump, call, return.
//  Adds stall, a post-reset boot cycle and a hardware return-address stack.
//  Sits between decode (pc_op/cond/operands) and instruction memory address (pc_o).
// PARAMETERS
//  PC_W        8   PC width in bits; all PC arithmetic is modulo 2^PC_W
//  OFF_W       8   signed relative-offset width; sign-extended or truncated to PC_W
//  DATA_W      16  register-operand width for JMP_REG
//  STACK_DEPTH 4   return-stack entries (>=1)
//  RESET_PC    0   PC value loaded by reset
// PORTS
//  system1000      in   1        clock, rising edge
//  system1000_rst  in   1        reset, asynchronous, active-high
//  en              in   1        advance enable; 0 = stall, all state held
//  pc_op           in   3        0 NEXT,1 JMP_ABS,2 JMP_REL,3 BR_ABS,4 BR_REL,5 JMP_REG,6 CALL,7 RET
//  cond            in   1        branch condition for BR_ABS/BR_REL
//  target          in   PC_W     absolute target (JMP_ABS, BR_ABS, CALL)
//  offset          in   OFF_W    signed offset (JMP_REL, BR_REL), relative to current pc_o
//  reg_val         in   DATA_W   signed register value (JMP_REG)
//  pc_o            out  PC_W     current PC (registered)
//  pc_valid_o      out  1        0 during boot cycle, 1 in RUN
//  sp_o            out  clog2(STACK_DEPTH+1)  return-stack occupancy
//  stack_err_o     out  2        [0] overflow, [1] underflow; only with PC_STACK_ERR_EN
// BEHAVIOUR
//  Reset (any time, incl. mid-operation): pc_o=RESET_PC, pc_valid_o=0, sp_o=0, stack_err_o=0, state=BOOT.
//  FSM: BOOT -> RUN on first clock edge with en=1 (pc_o unchanged, op ignored); RUN stays RUN until reset.
//  In RUN with en=1, next pc (latency 1 cycle, visible on pc_o next edge):
//   NEXT pc+1 | JMP_ABS target | JMP_REL pc+sext(offset) | BR_ABS cond?target:pc+1
//   BR_REL cond?pc+sext(offset):pc+1 | JMP_REG resize(reg_val) | CALL push pc+1, pc<=target
//   RET pc<=top, pop.
//  resize: DATA_W>=PC_W takes low PC_W bits; else sign-extends. Same rule for offset vs PC_W.
//  All adds wrap modulo 2^PC_W (pc=2^PC_W-1, NEXT -> 0).
//  en=0: pc_o, sp_o, stack, flags, state held; op ignored.
//  Stack is LIFO; pop/push take effect at same edge as PC update.
//  CALL with sp_o=STACK_DEPTH: jump still taken, push discarded, sp_o stays full.
//  RET with sp_o=0: pc<=pc+1, sp_o stays 0.
//  Ops/cond/operands sampled only on enabled RUN edges; no combinational input->output path.
// CONFIGURATION
//  PC_STACK_ERR_EN defined: stack_err_o present; bit0 sets on dropped CALL, bit1 on empty RET;
//   sticky until reset.
//  Not defined: port stack_err_o absent, no flag registers; PC/stack behaviour identical.
// STRUCTURE
//  Package pc_seq_pkg: opcode localparams (PCOP_NEXT..PCOP_RET), FSM state encoding
//   (ST_BOOT, ST_RUN), stack-error bit indices.
//  Sub-module pc_ret_stack (params PC_W, STACK_DEPTH): push/pop/data/top/sp/full/empty, register array;
//   sequencer holds FSM, next-PC mux, resize/adders.
// TESTING (PC_W=8, OFF_W=8, DATA_W=16, STACK_DEPTH=4, RESET_PC=0)
//  Reset, en=1, NEXT x3 -> pc_valid_o 0 then 1; pc_o 0,0,1,2; sp_o=0.
//  pc=0xFE, NEXT x2 -> 0xFF, 0x00; pc=0x10 JMP_REL offset=-3 -> 0x0D; JMP_REG reg_val=0x1234 -> 0x34.
//  BR_ABS target=0x40 cond=0 -> pc+1; cond=1 -> 0x40; BR_REL offset=+5 cond=1 at 0x40 -> 0x45.
//  CALL 0x20 at pc=0x05, RET -> pc 0x20 then 0x06; sp_o 1 then 0; en=0 between holds all.
//  5 nested CALLs -> 5th jumps, sp_o=4, stack_err_o[0]=1 (EN); 5 RETs -> 4 pops, 5th pc+1, err[1]=1.
//  Assert reset mid-CALL sequence -> pc_o=0, sp_o=0, flags 0, pc_valid_o=0 asynchronously.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: PC opcodes, FSM state
// encoding and return-stack error flag bit positions.
package pc_seq_pkg;

    // PC opcodes presented by decode
    localparam logic [2:0] PCOP_NEXT    = 3'd0;
    localparam logic [2:0] PCOP_JMP_ABS = 3'd1;
    localparam logic [2:0] PCOP_JMP_REL = 3'd2;
    localparam logic [2:0] PCOP_BR_ABS  = 3'd3;
    localparam logic [2:0] PCOP_BR_REL  = 3'd4;
    localparam logic [2:0] PCOP_JMP_REG = 3'd5;
    localparam logic [2:0] PCOP_CALL    = 3'd6;
    localparam logic [2:0] PCOP_RET     = 3'd7;

    // Sequencer states: one boot cycle after reset, then run forever
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_t;

    // Bit positions inside stack_err_o
    localparam int unsigned STK_ERR_OVF = 0;
    localparam int unsigned STK_ERR_UDF = 1;

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address stack (LIFO) for the PC sequencer.
// A push while full and a pop while empty are ignored; the caller decides what
// that means for the PC.
module pc_ret_stack #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               push_i,
    input  logic                               pop_i,
    input  logic [PC_W-1:0]                    data_i,
    output logic [PC_W-1:0]                    top_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_o,
    output logic                               full_o,
    output logic                               empty_o
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  mem_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Occupancy flags and top-of-stack read (entry below the stack pointer)
    always_comb begin
        full_o  = (sp_q == SP_W'(STACK_DEPTH));
        empty_o = (sp_q == '0);
        wr_idx  = IDX_W'(sp_q);
        rd_idx  = IDX_W'(sp_q - SP_W'(1));
        top_o   = empty_o ? '0 : mem_q[rd_idx];
        sp_o    = sp_q;
    end

    // Stack storage and pointer; push and pop are mutually exclusive by opcode
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
            sp_q          <= sp_q + SP_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer for the fetch stage.
// Holds a boot/run FSM, the next-PC mux with wrap-around adders, and a
// hardware return-address stack for CALL/RET.
// Optional feature macro: PC_STACK_ERR_EN adds sticky stack_err_o flags
// ([0] dropped CALL on full stack, [1] RET on empty stack).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned OFF_W       = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                               system1000,
    input  logic                               system1000_rst,
    input  logic                               en,
    input  logic [2:0]                         pc_op,
    input  logic                               cond,
    input  logic [PC_W-1:0]                    target,
    input  logic [OFF_W-1:0]                   offset,
    input  logic [DATA_W-1:0]                  reg_val,
    output logic [PC_W-1:0]                    pc_o,
    output logic                               pc_valid_o,
`ifdef PC_STACK_ERR_EN
    output logic [1:0]                         stack_err_o,
`endif
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_o
);

    pc_state_t       state_q;
    logic [PC_W-1:0] off_rs;
    logic [PC_W-1:0] reg_rs;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;
    logic [PC_W-1:0] pc_next;
    logic            adv;
    logic            stk_push;
    logic            stk_pop;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;

    // Fit the signed offset to PC width: truncate when wide, sign-extend when narrow
    if (OFF_W >= PC_W) begin : g_off_trunc
        assign off_rs = offset[PC_W-1:0];
        if (OFF_W > PC_W) begin : g_off_unused
            logic unused_off_hi;
            assign unused_off_hi = ^offset[OFF_W-1:PC_W];
        end
    end else begin : g_off_sext
        assign off_rs = {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};
    end

    // Same fitting rule for the register jump operand
    if (DATA_W >= PC_W) begin : g_reg_trunc
        assign reg_rs = reg_val[PC_W-1:0];
        if (DATA_W > PC_W) begin : g_reg_unused
            logic unused_reg_hi;
            assign unused_reg_hi = ^reg_val[DATA_W-1:PC_W];
        end
    end else begin : g_reg_sext
        assign reg_rs = {{(PC_W - DATA_W){reg_val[DATA_W-1]}}, reg_val};
    end

    // Next-PC selection and stack control; adds wrap modulo 2^PC_W
    always_comb begin
        adv      = en && (state_q == ST_RUN);
        pc_inc   = pc_o + PC_W'(1);
        pc_rel   = pc_o + off_rs;
        pc_next  = pc_inc;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        unique case (pc_op)
            PCOP_NEXT:    pc_next = pc_inc;
            PCOP_JMP_ABS: pc_next = target;
            PCOP_JMP_REL: pc_next = pc_rel;
            PCOP_BR_ABS:  pc_next = cond ? target : pc_inc;
            PCOP_BR_REL:  pc_next = cond ? pc_rel : pc_inc;
            PCOP_JMP_REG: pc_next = reg_rs;
            PCOP_CALL: begin
                // Jump is taken even when the return address cannot be saved
                pc_next  = target;
                stk_push = adv;
            end
            PCOP_RET: begin
                pc_next = stk_empty ? pc_inc : stk_top;
                stk_pop = adv;
            end
            default:      pc_next = pc_inc;
        endcase
    end

    // Boot/run FSM with registered PC and valid
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q    <= ST_BOOT;
            pc_o       <= PC_W'(RESET_PC);
            pc_valid_o <= 1'b0;
        end else if (en) begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_RUN;
                    pc_valid_o <= 1'b1;
                end
                ST_RUN: begin
                    pc_o <= pc_next;
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    pc_ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk_i   (system1000),
        .rst_i   (system1000_rst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .sp_o    (sp_o),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

`ifdef PC_STACK_ERR_EN
    logic ovf_evt;
    logic udf_evt;

    assign ovf_evt = stk_push && stk_full;
    assign udf_evt = stk_pop && stk_empty;

    // Sticky stack error flags, cleared only by reset
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            stack_err_o <= 2'b00;
        end else begin
            if (ovf_evt) stack_err_o[STK_ERR_OVF] <= 1'b1;
            if (udf_evt) stack_err_o[STK_ERR_UDF] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_W=8, OFF_W=8, DATA_W=16,
// STACK_DEPTH=4, RESET_PC=0). Define PC_STACK_ERR_EN to also check stack_err_o.
module tb_pc_sequencer;

    localparam logic [2:0] OP_NEXT = 3'd0, OP_JABS = 3'd1, OP_JREL = 3'd2, OP_BABS = 3'd3;
    localparam logic [2:0] OP_BREL = 3'd4, OP_JREG = 3'd5, OP_CALL = 3'd6, OP_RET = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  pc_op;
    logic        cond;
    logic [7:0]  target;
    logic [7:0]  offset;
    logic [15:0] reg_val;
    logic [7:0]  pc_o;
    logic        pc_valid_o;
    logic [2:0]  sp_o;
`ifdef PC_STACK_ERR_EN
    logic [1:0]  stack_err_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W        (8),
        .OFF_W       (8),
        .DATA_W      (16),
        .STACK_DEPTH (4),
        .RESET_PC    (0)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .en             (en),
        .pc_op          (pc_op),
        .cond           (cond),
        .target         (target),
        .offset         (offset),
        .reg_val        (reg_val),
        .pc_o           (pc_o),
        .pc_valid_o     (pc_valid_o),
`ifdef PC_STACK_ERR_EN
        .stack_err_o    (stack_err_o),
`endif
        .sp_o           (sp_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and clock it
    task automatic do_op(input logic [2:0] op, input logic c, input logic [7:0] tgt,
                         input logic [7:0] off, input logic [15:0] rv);
        pc_op   = op;
        cond    = c;
        target  = tgt;
        offset  = off;
        reg_val = rv;
        step();
    endtask

    task automatic check_err(input string tag, input logic [1:0] exp);
`ifdef PC_STACK_ERR_EN
        check_eq(tag, 32'(stack_err_o), 32'(exp));
`else
        if (exp === 2'bxx) $display("unreachable %s", tag);
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pc_op = OP_NEXT; cond = 1'b0;
        target = '0; offset = '0; reg_val = '0;
        step(); step();
        check_eq("rst_pc", 32'(pc_o), 32'h0);
        check_eq("rst_valid", 32'(pc_valid_o), 32'h0);
        check_eq("rst_sp", 32'(sp_o), 32'h0);
        check_err("rst_err", 2'b00);
        rst = 1'b0;

        // Stalled in BOOT: nothing moves
        step();
        check_eq("boot_stall_valid", 32'(pc_valid_o), 32'h0);
        check_eq("boot_stall_pc", 32'(pc_o), 32'h0);

        // Boot cycle then increments
        en = 1'b1;
        do_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("boot_valid", 32'(pc_valid_o), 32'h1);
        check_eq("boot_pc", 32'(pc_o), 32'h0);
        do_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("next1", 32'(pc_o), 32'h1);
        do_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("next2", 32'(pc_o), 32'h2);
        check_eq("next_sp", 32'(sp_o), 32'h0);

        // Wrap-around
        do_op(OP_JABS, 1'b0, 8'hFE, 8'h00, 16'h0);
        check_eq("jabs_fe", 32'(pc_o), 32'hFE);
        do_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("next_ff", 32'(pc_o), 32'hFF);
        do_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("next_wrap", 32'(pc_o), 32'h00);

        // Relative and register jumps
        do_op(OP_JABS, 1'b0, 8'h10, 8'h00, 16'h0);
        do_op(OP_JREL, 1'b0, 8'h00, 8'hFD, 16'h0);
        check_eq("jrel_neg3", 32'(pc_o), 32'h0D);
        do_op(OP_JREG, 1'b0, 8'h00, 8'h00, 16'h1234);
        check_eq("jreg_trunc", 32'(pc_o), 32'h34);

        // Branches
        do_op(OP_JABS, 1'b0, 8'h30, 8'h00, 16'h0);
        do_op(OP_BABS, 1'b0, 8'h40, 8'h00, 16'h0);
        check_eq("babs_nt", 32'(pc_o), 32'h31);
        do_op(OP_BABS, 1'b1, 8'h40, 8'h00, 16'h0);
        check_eq("babs_t", 32'(pc_o), 32'h40);
        do_op(OP_BREL, 1'b1, 8'h00, 8'h05, 16'h0);
        check_eq("brel_t", 32'(pc_o), 32'h45);
        do_op(OP_BREL, 1'b0, 8'h00, 8'h05, 16'h0);
        check_eq("brel_nt", 32'(pc_o), 32'h46);

        // CALL / stall / RET
        do_op(OP_JABS, 1'b0, 8'h05, 8'h00, 16'h0);
        do_op(OP_CALL, 1'b0, 8'h20, 8'h00, 16'h0);
        check_eq("call_pc", 32'(pc_o), 32'h20);
        check_eq("call_sp", 32'(sp_o), 32'h1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_op(OP_RET, 1'b1, 8'h77, 8'h01, 16'h0);
            check_eq("stall_pc", 32'(pc_o), 32'h20);
            check_eq("stall_sp", 32'(sp_o), 32'h1);
            check_eq("stall_valid", 32'(pc_valid_o), 32'h1);
        end
        en = 1'b1;
        do_op(OP_RET, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("ret_pc", 32'(pc_o), 32'h06);
        check_eq("ret_sp", 32'(sp_o), 32'h0);

        // Nested calls up to overflow
        do_op(OP_JABS, 1'b0, 8'h50, 8'h00, 16'h0);
        do_op(OP_CALL, 1'b0, 8'h60, 8'h00, 16'h0);  // saves 0x51
        do_op(OP_CALL, 1'b0, 8'h61, 8'h00, 16'h0);  // saves 0x61
        do_op(OP_CALL, 1'b0, 8'h70, 8'h00, 16'h0);  // saves 0x62
        do_op(OP_CALL, 1'b0, 8'h80, 8'h00, 16'h0);  // saves 0x71
        check_eq("nest4_sp", 32'(sp_o), 32'h4);
        check_err("nest4_err", 2'b00);
        do_op(OP_CALL, 1'b0, 8'h90, 8'h00, 16'h0);  // dropped
        check_eq("ovf_pc", 32'(pc_o), 32'h90);
        check_eq("ovf_sp", 32'(sp_o), 32'h4);
        check_err("ovf_err", 2'b01);

        // Unwind and underflow
        do_op(OP_RET, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("pop1_pc", 32'(pc_o), 32'h71);
        check_eq("pop1_sp", 32'(sp_o), 32'h3);
        do_op(OP_RET, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("pop2_pc", 32'(pc_o), 32'h62);
        do_op(OP_RET, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("pop3_pc", 32'(pc_o), 32'h61);
        do_op(OP_RET, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("pop4_pc", 32'(pc_o), 32'h51);
        check_eq("pop4_sp", 32'(sp_o), 32'h0);
        do_op(OP_RET, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("udf_pc", 32'(pc_o), 32'h52);
        check_eq("udf_sp", 32'(sp_o), 32'h0);
        check_err("udf_err", 2'b11);

        // Asynchronous reset in the middle of a call sequence
        do_op(OP_CALL, 1'b0, 8'h20, 8'h00, 16'h0);
        check_eq("pre_rst_sp", 32'(sp_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_pc", 32'(pc_o), 32'h0);
        check_eq("arst_sp", 32'(sp_o), 32'h0);
        check_eq("arst_valid", 32'(pc_valid_o), 32'h0);
        check_err("arst_err", 2'b00);
        step();
        rst = 1'b0;
        do_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("reboot_valid", 32'(pc_valid_o), 32'h1);
        check_eq("reboot_pc", 32'(pc_o), 32'h0);
        do_op(OP_NEXT, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("reboot_next", 32'(pc_o), 32'h1);
        // Stack must really be empty after reset
        do_op(OP_RET, 1'b0, 8'h00, 8'h00, 16'h0);
        check_eq("reboot_ret_pc", 32'(pc_o), 32'h2);
        check_eq("reboot_ret_sp", 32'(sp_o), 32'h0);
        check_err("reboot_err", 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
